// File: rtl/video_pkg.sv
// Shared definitions for the AXIS-to-video bridge supervisor: FSM encoding,
// bridge lock-state codes and the default active line width.
package video_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RESET_BRIDGE = 3'd1,
        ACQUIRE      = 3'd2,
        MONITOR      = 3'd3,
        RECOVER      = 3'd4
    } sup_state_e;

    localparam logic [1:0] UNLOCKED   = 2'd0;
    localparam logic [1:0] WAIT_FSYNC = 2'd1;
    localparam logic [1:0] LOCKED     = 2'd2;

    localparam int DEFAULT_H_ACTIVE = 1280;

endpackage

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear; holds at all-ones.
// Count is registered, so it reflects an increment one cycle after inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/video_sync_supervisor.sv
// Brings up the AXIS-to-video bridge, watches lock and stream integrity, and
// resets the bridge / restarts VDMA with frame-based backoff on sustained errors.
module video_sync_supervisor
    import video_pkg::*;
#(
    parameter int H_ACTIVE           = DEFAULT_H_ACTIVE,
    parameter int RST_CYCLES         = 16,
    parameter int ACQ_TIMEOUT_FRAMES = 4,
    parameter int ERR_LIMIT          = 2,
    parameter int BACKOFF_FRAMES     = 2,
    parameter int CNT_W              = 16
) (
    input  logic             video_clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [1:0]       bridge_state,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    input  logic             vtc_fsync,
    input  logic             vtc_active_video,
    output logic             bridge_resetn,
    output logic             vdma_restart,
    output logic             locked,
    output logic [2:0]       sup_state,
    output logic [CNT_W-1:0] underflow_cnt,
    output logic [CNT_W-1:0] line_err_cnt,
    output logic [CNT_W-1:0] recover_cnt
);

    localparam int LC_W = $clog2(H_ACTIVE) + 1;
    localparam int FW   = $clog2(((ACQ_TIMEOUT_FRAMES > BACKOFF_FRAMES) ?
                                  ACQ_TIMEOUT_FRAMES : BACKOFF_FRAMES) + 1);
    localparam int RW   = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam int EW   = $clog2(ERR_LIMIT + 1);
    localparam logic [LC_W:0] H_LEN = (LC_W + 1)'(H_ACTIVE);

    sup_state_e      state_q;
    logic            bridge_resetn_q, vdma_restart_q, locked_q;
    logic [RW-1:0]   rst_cnt_q;
    logic [FW-1:0]   frm_cnt_q;
    logic            fsync_d1_q;
    logic [LC_W-1:0] line_cnt_q;
    logic            frame_err_q, seen_rise_q, unl_q;
    logic [EW-1:0]   consec_q;

    // SOF is tapped for future use; nothing checks it yet.
    logic unused_tuser;
    assign unused_tuser = s_axis_tuser;

    logic            fsync_rise, beat, in_mon, nolock, underflow, line_err, err_evt;
    logic [LC_W:0]   line_nxt;
    logic [FW-1:0]   frm_nxt;
    logic            enter_mon, mon_err_trip, mon_nolock_trip, acq_tmo, rec_done, rst_done;

    assign fsync_rise = vtc_fsync & ~fsync_d1_q;
    assign beat       = s_axis_tvalid & s_axis_tready;
    assign in_mon     = (state_q == MONITOR);
    assign nolock     = (bridge_state != LOCKED);
    assign line_nxt   = {1'b0, line_cnt_q} + 1'b1;
    assign line_err   = beat & ((s_axis_tlast & (line_nxt != H_LEN)) |
                                (~s_axis_tlast & (line_nxt == H_LEN + 1'b1)));
    assign underflow  = in_mon & vtc_active_video & s_axis_tready & ~s_axis_tvalid;
    assign err_evt    = underflow | line_err;

    assign frm_nxt         = frm_cnt_q + 1'b1;
    assign enter_mon       = enable & (state_q == ACQUIRE) & ~nolock;
    assign mon_err_trip    = fsync_rise & frame_err_q & ((consec_q + 1'b1) == EW'(ERR_LIMIT));
    assign mon_nolock_trip = fsync_rise & seen_rise_q & unl_q;
    assign acq_tmo         = fsync_rise & (frm_nxt == FW'(ACQ_TIMEOUT_FRAMES));
    assign rec_done        = fsync_rise & (frm_nxt == FW'(BACKOFF_FRAMES));
    assign rst_done        = (rst_cnt_q == RW'(RST_CYCLES - 1));

    always_ff @(posedge video_clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            bridge_resetn_q <= 1'b0;
            vdma_restart_q  <= 1'b0;
            locked_q        <= 1'b0;
            rst_cnt_q       <= '0;
            frm_cnt_q       <= '0;
        end else begin
            vdma_restart_q <= 1'b0;
            rst_cnt_q      <= '0;
            if (!enable) begin
                state_q         <= IDLE;
                bridge_resetn_q <= 1'b0;
                locked_q        <= 1'b0;
                frm_cnt_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= RESET_BRIDGE;
                    RESET_BRIDGE: begin
                        if (rst_done) begin
                            state_q         <= ACQUIRE;
                            bridge_resetn_q <= 1'b1;
                            frm_cnt_q       <= '0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end
                    ACQUIRE: begin
                        // Lock takes priority over a coincident timeout edge.
                        if (!nolock) begin
                            state_q  <= MONITOR;
                            locked_q <= 1'b1;
                        end else if (acq_tmo) begin
                            state_q         <= RECOVER;
                            bridge_resetn_q <= 1'b0;
                            vdma_restart_q  <= 1'b1;
                            frm_cnt_q       <= '0;
                        end else if (fsync_rise) begin
                            frm_cnt_q <= frm_nxt;
                        end
                    end
                    MONITOR: begin
                        if (mon_err_trip || mon_nolock_trip) begin
                            state_q         <= RECOVER;
                            locked_q        <= 1'b0;
                            bridge_resetn_q <= 1'b0;
                            vdma_restart_q  <= 1'b1;
                            frm_cnt_q       <= '0;
                        end
                    end
                    RECOVER: begin
                        if (rec_done) begin
                            state_q   <= RESET_BRIDGE;
                            frm_cnt_q <= '0;
                        end else if (fsync_rise) begin
                            frm_cnt_q <= frm_nxt;
                        end
                    end
                    default: begin
                        state_q         <= IDLE;
                        bridge_resetn_q <= 1'b0;
                        locked_q        <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Frame-error bookkeeping only runs in MONITOR; an error coincident with
    // fsync_rise is charged to the frame that starts on that edge.
    always_ff @(posedge video_clk) begin
        if (!resetn) begin
            fsync_d1_q  <= 1'b0;
            line_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            consec_q    <= '0;
            seen_rise_q <= 1'b0;
            unl_q       <= 1'b0;
        end else begin
            fsync_d1_q <= vtc_fsync;
            if (enter_mon) begin
                line_cnt_q <= '0;
            end else if (beat) begin
                if (s_axis_tlast) begin
                    line_cnt_q <= '0;
                end else if (line_cnt_q != '1) begin
                    line_cnt_q <= line_cnt_q + 1'b1;
                end
            end
            if (!in_mon) begin
                frame_err_q <= 1'b0;
                consec_q    <= '0;
                seen_rise_q <= 1'b0;
                unl_q       <= 1'b0;
            end else if (fsync_rise) begin
                frame_err_q <= err_evt;
                consec_q    <= frame_err_q ? consec_q + 1'b1 : '0;
                seen_rise_q <= 1'b1;
                unl_q       <= nolock;
            end else begin
                frame_err_q <= frame_err_q | err_evt;
                unl_q       <= unl_q & nolock;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_underflow_cnt (
        .clk (video_clk), .clr (~resetn), .inc (underflow),      .cnt (underflow_cnt));
    sat_counter #(.W(CNT_W)) u_line_err_cnt (
        .clk (video_clk), .clr (~resetn), .inc (line_err),       .cnt (line_err_cnt));
    sat_counter #(.W(CNT_W)) u_recover_cnt (
        .clk (video_clk), .clr (~resetn), .inc (vdma_restart_q), .cnt (recover_cnt));

    assign bridge_resetn = bridge_resetn_q;
    assign vdma_restart  = vdma_restart_q;
    assign locked        = locked_q;
    assign sup_state     = state_q;

endmodule

// File: tb/tb_video_sync_supervisor.sv
// Directed bench for video_sync_supervisor: bring-up, line/underflow errors,
// recovery with backoff, acquire timeout, disable and reset mid-operation.
module tb_video_sync_supervisor;

    logic        video_clk = 1'b0;
    logic        resetn, enable;
    logic [1:0]  bridge_state;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic        vtc_fsync, vtc_active_video;
    logic        bridge_resetn, vdma_restart, locked;
    logic [2:0]  sup_state;
    logic [15:0] underflow_cnt, line_err_cnt, recover_cnt;

    int checks   = 0;
    int failures = 0;
    int vdma_pulses = 0;

    always #5 video_clk = ~video_clk;

    always @(negedge video_clk) begin
        if (vdma_restart === 1'b1) vdma_pulses <= vdma_pulses + 1;
    end

    video_sync_supervisor dut (
        .video_clk        (video_clk),
        .resetn           (resetn),
        .enable           (enable),
        .bridge_state     (bridge_state),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .vtc_fsync        (vtc_fsync),
        .vtc_active_video (vtc_active_video),
        .bridge_resetn    (bridge_resetn),
        .vdma_restart     (vdma_restart),
        .locked           (locked),
        .sup_state        (sup_state),
        .underflow_cnt    (underflow_cnt),
        .line_err_cnt     (line_err_cnt),
        .recover_cnt      (recover_cnt)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge video_clk);
            #1;
        end
    endtask

    task automatic fsync_pulse();
        vtc_fsync = 1'b1;
        tick();
        vtc_fsync = 1'b0;
        tick();
    endtask

    task automatic send_line(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid    = 1'b1;
            s_axis_tready    = 1'b1;
            vtc_active_video = 1'b1;
            s_axis_tlast     = with_last && (i == n - 1);
            tick();
        end
        s_axis_tvalid    = 1'b0;
        s_axis_tready    = 1'b0;
        vtc_active_video = 1'b0;
        s_axis_tlast     = 1'b0;
        tick();
    endtask

    task automatic storm10();
        vtc_active_video = 1'b1;
        s_axis_tready    = 1'b1;
        s_axis_tvalid    = 1'b0;
        tick(10);
        vtc_active_video = 1'b0;
        s_axis_tready    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; bridge_state = 2'd0;
        s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        vtc_fsync = 1'b0; vtc_active_video = 1'b0;
        tick(3);
        checks++;
        if ({bridge_resetn, vdma_restart, locked} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs: got %b expected 000", {bridge_resetn, vdma_restart, locked});
        end
        checks++;
        if (sup_state !== 3'd0) begin
            failures++; $display("FAIL reset_state: got %0d expected 0", sup_state);
        end
        checks++;
        if ({underflow_cnt, line_err_cnt, recover_cnt} !== 48'd0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", underflow_cnt, line_err_cnt, recover_cnt);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_bringup();
        int n_low;
        int guard;
        enable = 1'b1;
        tick();
        n_low = 0;
        guard = 0;
        while (sup_state === 3'd1 && guard < 40) begin
            if (bridge_resetn === 1'b0) n_low++;
            guard++;
            tick();
        end
        checks++;
        if (n_low != 16 || guard != 16) begin
            failures++; $display("FAIL bringup_rst_len: got %0d low of %0d cycles expected 16", n_low, guard);
        end
        checks++;
        if (sup_state !== 3'd2 || bridge_resetn !== 1'b1) begin
            failures++; $display("FAIL bringup_acquire: got state %0d bridge_resetn %b expected 2/1", sup_state, bridge_resetn);
        end
        tick(2);
        checks++;
        if (locked !== 1'b0 || sup_state !== 3'd2) begin
            failures++; $display("FAIL bringup_not_locked: got locked %b state %0d expected 0/2", locked, sup_state);
        end
        bridge_state = 2'd2;
        tick();
        checks++;
        if (locked !== 1'b1 || sup_state !== 3'd3) begin
            failures++; $display("FAIL bringup_locked: got locked %b state %0d expected 1/3", locked, sup_state);
        end
    endtask

    task automatic test_good_video();
        for (int f = 0; f < 3; f++) begin
            fsync_pulse();
            send_line(1280, 1'b1);
        end
        checks++;
        if (line_err_cnt !== 16'd0 || underflow_cnt !== 16'd0) begin
            failures++; $display("FAIL good_video_errs: got line_err %0d underflow %0d expected 0/0", line_err_cnt, underflow_cnt);
        end
        checks++;
        if (locked !== 1'b1 || sup_state !== 3'd3) begin
            failures++; $display("FAIL good_video_locked: got locked %b state %0d expected 1/3", locked, sup_state);
        end
    endtask

    task automatic test_short_line();
        fsync_pulse();
        send_line(1279, 1'b1);
        checks++;
        if (line_err_cnt !== 16'd1) begin
            failures++; $display("FAIL short_line_cnt: got %0d expected 1", line_err_cnt);
        end
        fsync_pulse();
        send_line(1280, 1'b1);
        fsync_pulse();
        checks++;
        if (locked !== 1'b1 || sup_state !== 3'd3) begin
            failures++; $display("FAIL short_line_locked: got locked %b state %0d expected 1/3", locked, sup_state);
        end
        // Overlong line: flagged once at beat 1281, again at the late TLAST.
        send_line(1282, 1'b1);
        checks++;
        if (line_err_cnt !== 16'd3) begin
            failures++; $display("FAIL long_line_cnt: got %0d expected 3", line_err_cnt);
        end
        fsync_pulse();
        checks++;
        if (locked !== 1'b1 || sup_state !== 3'd3) begin
            failures++; $display("FAIL consec_reset: got locked %b state %0d expected 1/3", locked, sup_state);
        end
        send_line(1280, 1'b1);
        fsync_pulse();
    endtask

    task automatic test_underflow_storm();
        int p0;
        p0 = vdma_pulses;
        storm10();
        fsync_pulse();
        checks++;
        if (sup_state !== 3'd3 || underflow_cnt !== 16'd10) begin
            failures++; $display("FAIL storm_first_frame: got state %0d underflow %0d expected 3/10", sup_state, underflow_cnt);
        end
        storm10();
        vtc_fsync = 1'b1;
        tick();
        checks++;
        if (sup_state !== 3'd4 || vdma_restart !== 1'b1 || bridge_resetn !== 1'b0) begin
            failures++; $display("FAIL storm_recover: got state %0d restart %b bridge_resetn %b expected 4/1/0", sup_state, vdma_restart, bridge_resetn);
        end
        vtc_fsync = 1'b0;
        tick();
        checks++;
        if (vdma_restart !== 1'b0 || recover_cnt !== 16'd1 || underflow_cnt !== 16'd20) begin
            failures++; $display("FAIL storm_counts: got restart %b recover %0d underflow %0d expected 0/1/20", vdma_restart, recover_cnt, underflow_cnt);
        end
        fsync_pulse();
        checks++;
        if (sup_state !== 3'd4) begin
            failures++; $display("FAIL backoff_wait: got state %0d expected 4", sup_state);
        end
        vtc_fsync = 1'b1;
        tick();
        vtc_fsync = 1'b0;
        checks++;
        if (sup_state !== 3'd1 || bridge_resetn !== 1'b0 || vdma_pulses - p0 != 1) begin
            failures++; $display("FAIL backoff_done: got state %0d bridge_resetn %b pulses %0d expected 1/0/1", sup_state, bridge_resetn, vdma_pulses - p0);
        end
        tick(16);
        checks++;
        if (sup_state !== 3'd2 || line_err_cnt !== 16'd3) begin
            failures++; $display("FAIL rereset_acquire: got state %0d line_err %0d expected 2/3", sup_state, line_err_cnt);
        end
    endtask

    task automatic test_acq_timeout();
        int p0;
        bridge_state = 2'd0;
        repeat (3) fsync_pulse();
        checks++;
        if (sup_state !== 3'd2) begin
            failures++; $display("FAIL acq_before_timeout: got state %0d expected 2", sup_state);
        end
        vtc_fsync = 1'b1;
        tick();
        vtc_fsync = 1'b0;
        checks++;
        if (sup_state !== 3'd4 || vdma_restart !== 1'b1) begin
            failures++; $display("FAIL acq_timeout: got state %0d restart %b expected 4/1", sup_state, vdma_restart);
        end
        tick();
        checks++;
        if (recover_cnt !== 16'd2) begin
            failures++; $display("FAIL acq_recover_cnt: got %0d expected 2", recover_cnt);
        end
        repeat (2) fsync_pulse();
        tick(15);
        checks++;
        if (sup_state !== 3'd2) begin
            failures++; $display("FAIL acq_reenter: got state %0d expected 2", sup_state);
        end
        p0 = vdma_pulses;
        repeat (3) fsync_pulse();
        vtc_fsync = 1'b1;
        bridge_state = 2'd2;
        tick();
        vtc_fsync = 1'b0;
        tick();
        checks++;
        if (sup_state !== 3'd3 || locked !== 1'b1 || vdma_pulses != p0) begin
            failures++; $display("FAIL acq_lock_wins: got state %0d locked %b pulses %0d expected 3/1/0", sup_state, locked, vdma_pulses - p0);
        end
    endtask

    task automatic test_mid_operation();
        int p0;
        p0 = vdma_pulses;
        enable = 1'b0;
        tick();
        checks++;
        if (sup_state !== 3'd0 || bridge_resetn !== 1'b0 || locked !== 1'b0) begin
            failures++; $display("FAIL disable_idle: got state %0d bridge_resetn %b locked %b expected 0/0/0", sup_state, bridge_resetn, locked);
        end
        storm10();
        checks++;
        if (vdma_pulses != p0 || underflow_cnt !== 16'd20 || recover_cnt !== 16'd2) begin
            failures++; $display("FAIL disable_hold: got pulses %0d underflow %0d recover %0d expected 0/20/2", vdma_pulses - p0, underflow_cnt, recover_cnt);
        end
        enable = 1'b1;
        bridge_state = 2'd0;
        tick(17);
        repeat (4) fsync_pulse();
        checks++;
        if (sup_state !== 3'd4 || recover_cnt !== 16'd3) begin
            failures++; $display("FAIL reach_recover: got state %0d recover %0d expected 4/3", sup_state, recover_cnt);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (sup_state !== 3'd0 || {bridge_resetn, vdma_restart, locked} !== 3'b000) begin
            failures++; $display("FAIL reset_in_recover: got state %0d outs %b expected 0/000", sup_state, {bridge_resetn, vdma_restart, locked});
        end
        checks++;
        if ({underflow_cnt, line_err_cnt, recover_cnt} !== 48'd0) begin
            failures++; $display("FAIL reset_in_recover_cnt: got %0d/%0d/%0d expected 0/0/0", underflow_cnt, line_err_cnt, recover_cnt);
        end
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bringup();
        test_good_video();
        test_short_line();
        test_underflow_storm();
        test_acq_timeout();
        test_mid_operation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_sync_supervisor.md
Name: video_sync_supervisor

Overview:
- Controller for the AXI-Stream-to-video bridge on the video_clk domain.
- Sequences bridge bring-up, monitors the lock state and stream integrity, and counts underflows and bad line lengths.
- On sustained errors, resets the bridge and requests a VDMA MM2S restart with frame-based backoff.
- Sits beside the bridge; taps its AXIS handshake and VTC timing. Configured and observed by software through status ports.

Parameters:
- H_ACTIVE, 1280, expected accepted beats per line (TLAST on beat H_ACTIVE).
- RST_CYCLES, 16, bridge reset hold length in cycles (>=2).
- ACQ_TIMEOUT_FRAMES, 4, fsync edges allowed in ACQUIRE before recovery.
- ERR_LIMIT, 2, consecutive errored frames in MONITOR that trigger recovery.
- BACKOFF_FRAMES, 2, fsync edges to wait in RECOVER before re-reset.
- CNT_W, 16, width of saturating error counters.

Ports:
- video_clk  in  1  pixel clock; all logic is on its rising edge.
- resetn  in  1  synchronous active-low reset, sampled on video_clk.
- enable  in  1  software run bit; low forces IDLE.
- bridge_state  in  2  bridge lock state: 0 unlocked, 1 wait-fsync, 2 locked.
- s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser  in  1 each  taps of the bridge input handshake.
- vtc_fsync  in  1  VTC frame sync, level.
- vtc_active_video  in  1  VTC active video.
- bridge_resetn  out  1  active-low reset to the bridge.
- vdma_restart  out  1  one-cycle restart request to the VDMA control sequencer.
- locked  out  1  high only in MONITOR.
- sup_state  out  3  current FSM state encoding.
- underflow_cnt  out  CNT_W  saturating count of underflow cycles.
- line_err_cnt  out  CNT_W  saturating count of bad-length lines.
- recover_cnt  out  CNT_W  saturating count of RECOVER entries.

Behaviour:
- Reset values:
  - bridge_resetn=0, vdma_restart=0, locked=0.
  - sup_state=IDLE, all counters 0.
  - The fsync delay register is also cleared to 0.
- Reset mid-operation returns to the reset values on the next edge.
- fsync_rise is vtc_fsync & ~fsync_d1, using a one-register delay. All frame-based counts use fsync_rise.
- beat = s_axis_tvalid & s_axis_tready.
- Line counter:
  - Increments on beat and saturates at 2^(clog2(H_ACTIVE)+1)-1.
  - Clears to 0 on a beat with tlast.
  - Clears on entry to MONITOR.
- Line error: a beat with tlast where counter+1 != H_ACTIVE. Also counter+1 reaching H_ACTIVE+1 without tlast; this flags once per line.
- Underflow: vtc_active_video & s_axis_tready & ~s_axis_tvalid while in MONITOR.
- Error counters update one cycle after the event (registered) and saturate at all-ones, never wrapping.
- frame_err flag:
  - Sets on any underflow or line error.
  - On fsync_rise it is sampled into the consecutive-errored-frame counter, then cleared.
  - If the consecutive counter is not incremented on that fsync_rise, it clears.
  - An error in the same cycle as fsync_rise counts toward the new frame.
- FSM (one transition per cycle max):
  - IDLE: bridge_resetn=0. Goes to RESET_BRIDGE when enable=1.
  - RESET_BRIDGE: bridge_resetn=0 for exactly RST_CYCLES cycles, then ACQUIRE. bridge_resetn rises in the first ACQUIRE cycle.
  - ACQUIRE: bridge_resetn=1, frame counter runs on fsync_rise.
    - bridge_state==2 -> MONITOR.
    - Frame counter reaching ACQ_TIMEOUT_FRAMES -> RECOVER.
    - If both happen in the same cycle, lock wins.
  - MONITOR: locked=1.
    - Consecutive errored frames reaching ERR_LIMIT -> RECOVER.
    - bridge_state!=2 for a full frame (fsync_rise to fsync_rise) -> RECOVER.
  - RECOVER:
    - On entry: vdma_restart=1 for exactly one cycle, recover_cnt+1, bridge_resetn=0.
    - Waits BACKOFF_FRAMES fsync_rise edges, then goes to RESET_BRIDGE.
  - enable=0 in any state -> IDLE next cycle. This overrides all other transitions, and no vdma_restart is issued.
- Counters keep their values across FSM transitions. They clear only on resetn.

Decomposition:
- Shared package video_pkg holds:
  - the supervisor state enum (IDLE=0, RESET_BRIDGE=1, ACQUIRE=2, MONITOR=3, RECOVER=4);
  - the bridge state constants (UNLOCKED=0, WAIT_FSYNC=1, LOCKED=2);
  - the default H_ACTIVE.
- One sub-module, sat_counter: parameterized-width saturating incrementer with a synchronous clear. It is instantiated for the three error counters.

Test Plan:
1. Bring-up: reset, enable=1, RST_CYCLES=16 -> bridge_resetn low for 16 cycles. bridge_state=2 driven on the 3rd ACQUIRE cycle -> locked=1 next cycle, sup_state=3.
2. Good video: 3 frames of 1280-beat lines with TLAST on beat 1280 -> line_err_cnt=0, underflow_cnt=0, locked stays 1.
3. Short line: one 1279-beat line with TLAST -> line_err_cnt=1, still locked (ERR_LIMIT=2). A clean next frame resets the consecutive count.
4. Underflow storm: tvalid=0 for 10 active cycles in each of 2 consecutive frames -> underflow_cnt=20. On the 2nd fsync_rise: RECOVER, one vdma_restart pulse, recover_cnt=1. After 2 fsync edges, RESET_BRIDGE.
5. Acquire timeout: bridge_state held at 0 -> RECOVER at the 4th fsync_rise. With bridge_state=2 in the same cycle as that 4th fsync_rise -> MONITOR instead.
6. Mid-operation control: enable=0 while in MONITOR -> IDLE next cycle, bridge_resetn=0, no vdma_restart. resetn=0 in RECOVER -> all outputs at reset values and counters=0.
